// File: rtl/mem_access_unit.sv
// Load/store unit between the RV32I datapath and the word-aligned L1 data cache port.
// Optional response timeout is enabled by defining MAU_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | cpu_ready=1, a request is accepted on this edge
// ST_READ  | mem_read strobe held until mem_resp (or timeout)
// ST_WRITE | mem_write strobe held until mem_resp (or timeout)
// ST_FAULT | misaligned / illegal funct3, nothing issued to the cache
// ST_RESP  | one-cycle cpu_resp with data and flags
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        cpu_ready,
  output logic        cpu_resp,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misaligned,
  output logic        cpu_timeout,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FAULT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic        timeout_q;

  logic        accept;
  logic        busy;
  logic        req_legal;
  logic [3:0]  req_be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic        tmo_expire;

  if (2**TMO_W <= TIMEOUT_CYCLES) begin : g_tmo_w_check
    $error("TMO_W is too narrow to count TIMEOUT_CYCLES");
  end

  assign accept = (state_q == ST_IDLE) && (req_read || req_write);
  assign busy   = (state_q == ST_READ) || (state_q == ST_WRITE);

  // Loads accept b/h/w/bu/hu; stores only b/h/w. Read wins when both are requested.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000:  req_legal = 1'b1;
      3'b100:  req_legal = req_read;
      3'b001:  req_legal = ~req_addr[0];
      3'b101:  req_legal = req_read & ~req_addr[0];
      3'b010:  req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    req_be = 4'b1111;
    if (!req_read) begin
      case (req_funct3)
        3'b000:  req_be = 4'b0001 << req_addr[1:0];
        3'b001:  req_be = 4'b0011 << req_addr[1:0];
        default: req_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    lane_b = 8'h00;
    case (off_q)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h000000, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0000, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

`ifdef MAU_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (busy) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Count reaches TIMEOUT_CYCLES-1 during the last allowed strobe cycle.
  assign tmo_expire = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!req_legal)    state_d = ST_FAULT;
          else if (req_read) state_d = ST_READ;
          else               state_d = ST_WRITE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (mem_resp || tmo_expire) state_d = ST_RESP;
      end
      ST_FAULT: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      funct3_q        <= '0;
      off_q           <= '0;
    end else if (accept) begin
      mem_address     <= {req_addr[31:2], 2'b00};
      mem_wdata       <= req_wdata << {req_addr[1:0], 3'b000};
      mem_byte_enable <= req_be;
      funct3_q        <= req_funct3;
      off_q           <= req_addr[1:0];
    end
  end

  // Result and flags are loaded only on entry to ST_RESP, so cpu_rdata holds in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (busy && mem_resp) begin
        rdata_q      <= (state_q == ST_READ) ? load_ext : 32'h0;
        misaligned_q <= 1'b0;
        timeout_q    <= 1'b0;
      end else if (tmo_expire) begin
        rdata_q      <= 32'h0;
        misaligned_q <= 1'b0;
        timeout_q    <= 1'b1;
      end else if (state_q == ST_FAULT) begin
        rdata_q      <= 32'h0;
        misaligned_q <= 1'b1;
        timeout_q    <= 1'b0;
      end
    end
  end

  assign cpu_ready      = (state_q == ST_IDLE);
  assign cpu_resp       = (state_q == ST_RESP);
  assign cpu_rdata      = rdata_q;
  assign cpu_misaligned = misaligned_q;
  assign cpu_timeout    = timeout_q;
  assign mem_read       = (state_q == ST_READ);
  assign mem_write      = (state_q == ST_WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a cache responder and an arithmetic reference model.
// Timeout checks run only when MAU_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        cpu_ready, cpu_resp, cpu_misaligned, cpu_timeout;
  logic [31:0] cpu_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
    .cpu_misaligned(cpu_misaligned), .cpu_timeout(cpu_timeout),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, extension by integer arithmetic.
  task automatic model(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       output bit fault, output logic [31:0] e_wdata,
                       output logic [3:0] e_be, output logic [31:0] e_rdata);
    int     size;
    int     off;
    bit     legal;
    longint v;
    off   = int'(addr % 4);
    legal = rd ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    size  = 1 << f3[1:0];
    fault = !legal || (off % size != 0);
    e_wdata = wdata << (8 * off);
    e_be    = rd ? 4'hF : 4'(((1 << size) - 1) << off);
    e_rdata = 32'h0;
    if (rd && !fault) begin
      v = longint'(rdata >> (8 * off));
      if (size < 4) begin
        v = v % (longint'(1) << (8 * size));
        if (!f3[2] && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      end
      e_rdata = 32'(v);
    end
  endtask

  // One transaction; delay = strobe cycle on which mem_resp is returned.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input int delay,
                        input logic [31:0] rdata, input bit exp_tmo);
    bit          fault;
    logic [31:0] e_wdata, e_rdata, e_addr;
    logic [3:0]  e_be;
    int          strobes = 0;
    int          resp_cyc = 0;
    int          waited = 0;
    bit          unstable = 0;
    logic        st_rd = 0, st_wr = 0;
    logic [31:0] st_addr = 0, st_wdata = 0;
    logic [3:0]  st_be = 0;
    model(rd, f3, addr, wdata, rdata, fault, e_wdata, e_be, e_rdata);
    if (exp_tmo) e_rdata = 32'h0;
    e_addr = addr & 32'hFFFF_FFFC;

    @(negedge clk);
    while (!cpu_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check_eq("ready_before_req", 32'(cpu_ready), 32'd1);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk);
    #1;
    req_read = 1'b0; req_write = 1'b0;

    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (cpu_resp) begin
        resp_cyc = c;
        break;
      end
      if (mem_read || mem_write) begin
        strobes++;
        if (strobes == 1) begin
          st_rd = mem_read; st_wr = mem_write; st_addr = mem_address;
          st_wdata = mem_wdata; st_be = mem_byte_enable;
        end else if (mem_read !== st_rd || mem_write !== st_wr || mem_address !== st_addr ||
                     mem_wdata !== st_wdata || mem_byte_enable !== st_be) begin
          unstable = 1;
        end
        if (!exp_tmo && strobes == delay) begin
          mem_resp = 1'b1; mem_rdata = rdata;
        end
      end else if (fault && c == 1) begin
        mem_resp = 1'b1; mem_rdata = $urandom;
      end
      req_read = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom_range(0, 7));
      if (mem_resp) begin
        @(posedge clk);
        #1;
        mem_resp = 1'b0; mem_rdata = $urandom;
      end
    end
    req_read = 1'b0; req_write = 1'b0;

    check_eq("resp_cycle", 32'(resp_cyc), fault ? 32'd2 : 32'(delay + 1));
    check_eq("strobe_count", 32'(strobes), fault ? 32'd0 : 32'(delay));
    if (!fault) begin
      check_eq("strobe_kind", {30'h0, st_rd, st_wr}, rd ? 32'd2 : 32'd1);
      check_eq("mem_address", st_addr, e_addr);
      check_eq("byte_enable", {28'h0, st_be}, {28'h0, e_be});
      if (!rd) check_eq("mem_wdata", st_wdata, e_wdata);
      check_eq("strobe_stable", 32'(unstable), 32'd0);
    end
    check_eq("cpu_rdata", cpu_rdata, e_rdata);
    check_eq("cpu_misaligned", 32'(cpu_misaligned), 32'(fault));
    check_eq("cpu_timeout", 32'(cpu_timeout), 32'(exp_tmo));

    @(negedge clk);
    check_eq("resp_single_pulse", {30'h0, cpu_resp, cpu_ready}, 32'd1);
    check_eq("rdata_held", cpu_rdata, e_rdata);
    check_eq("idle_no_strobe", {30'h0, mem_read, mem_write}, 32'd0);
  endtask

  initial begin
    bit rd, wr;
    int op;
    rst = 1'b1;
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
    mem_rdata = 0; mem_resp = 0;
    #2;
    check_eq("reset_outputs",
             {26'h0, cpu_ready, cpu_resp, cpu_misaligned, cpu_timeout, mem_read, mem_write},
             32'h20);
    check_eq("reset_rdata", cpu_rdata, 32'h0);
    check_eq("reset_address", mem_address, 32'h0);
    check_eq("reset_be", {28'h0, mem_byte_enable}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(1, 0, 32'h100, 32'h0, 3'b010, 3, 32'hDEADBEEF, 0);
    check_eq("lw_directed", cpu_rdata, 32'hDEADBEEF);
    do_req(1, 0, 32'h103, 32'h0, 3'b000, 1, 32'h80123456, 0);
    check_eq("lb_directed", cpu_rdata, 32'hFFFFFF80);
    do_req(1, 0, 32'h103, 32'h0, 3'b100, 2, 32'h80123456, 0);
    check_eq("lbu_directed", cpu_rdata, 32'h00000080);
    do_req(1, 0, 32'h102, 32'h0, 3'b101, 1, 32'h80123456, 0);
    check_eq("lhu_directed", cpu_rdata, 32'h00008012);
    do_req(0, 1, 32'h102, 32'h1234ABCD, 3'b001, 2, 32'h0, 0);
    do_req(1, 0, 32'h101, 32'h0, 3'b010, 1, 32'h0, 0);
    do_req(0, 1, 32'h103, 32'h55AA55AA, 3'b001, 1, 32'h0, 0);
    do_req(1, 1, 32'h200, 32'hCAFEF00D, 3'b010, 2, 32'h01234567, 0);
    do_req(1, 0, 32'h204, 32'h0, 3'b011, 1, 32'h0, 0);
    do_req(0, 1, 32'h208, 32'h0, 3'b100, 1, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      do_req(rd, wr, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(1, 4),
             $urandom, 0);
    end

`ifdef MAU_TIMEOUT_EN
    do_req(1, 0, 32'h300, 32'h0, 3'b010, 4, 32'h0, 1);
    do_req(0, 1, 32'h304, 32'h11223344, 3'b010, 4, 32'h0, 1);
`endif

    // Reset in the middle of a read, then a stale mem_resp.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h400; req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_read = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_pre_strobe", 32'(mem_read), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_strobe_drop", {30'h0, mem_read, mem_write}, 32'd0);
    check_eq("rst_mid_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("late_resp_ignored", {29'h0, cpu_resp, cpu_ready, mem_read}, 32'd2);
    end
    check_eq("late_resp_rdata", cpu_rdata, 32'h0);

    do_req(1, 0, 32'h404, 32'h0, 3'b001, 2, 32'h0000F00F, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
